// File: rtl/data_memory_io.sv
// Data RAM with a memory-mapped I/O window (STATUS, input ports, output ports) at the top of
// the address space. Define DATA_MEMORY_IO_READBACK_EN to make output-port registers readable.
module data_memory_io #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_IN   = 1,
  parameter int unsigned N_OUT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic                    in_write_en,
  input  logic                    in_read_en,
  input  logic [DATA_W-1:0]       in_data,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_read_valid,
  input  logic [N_IN*DATA_W-1:0]  in_port_data,
  input  logic [N_IN-1:0]         in_port_valid,
  output logic [N_IN-1:0]         in_port_ready,
  output logic [N_OUT*DATA_W-1:0] out_port_data,
  output logic [N_OUT-1:0]        out_port_wr
);

  localparam int unsigned Top     = (2 ** ADDR_W) - 1;
  localparam int unsigned IoBase  = Top - N_IN - N_OUT;
  localparam logic [ADDR_W-1:0] IoBaseA = ADDR_W'(IoBase);

  logic [DATA_W-1:0]       mem_q [IoBase];
  logic [N_IN-1:0]         full_q, full_d;
  logic [N_IN*DATA_W-1:0]  hold_q, hold_d;
  logic [N_OUT*DATA_W-1:0] out_port_q, out_port_d;
  logic [N_OUT-1:0]        out_wr_q, out_wr_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    read_valid_q, read_valid_d;
  logic [DATA_W-1:0]       rd_data;
  logic                    is_ram;

  assign is_ram = in_addr < IoBaseA;

  // Read mux sees pre-edge state, which gives read-first and pre-capture semantics for free.
  always_comb begin : read_mux
    rd_data = '0;
    if (is_ram) begin
      rd_data = mem_q[in_addr];
    end
    if (in_addr == IoBaseA) begin
      rd_data[N_IN-1:0] = full_q;
    end
    for (int i = 0; i < N_IN; i++) begin
      if (in_addr == ADDR_W'(IoBase + 1 + i)) begin
        rd_data = hold_q[i*DATA_W +: DATA_W];
      end
    end
`ifdef DATA_MEMORY_IO_READBACK_EN
    for (int j = 0; j < N_OUT; j++) begin
      if (in_addr == ADDR_W'(IoBase + 1 + N_IN + j)) begin
        rd_data = out_port_q[j*DATA_W +: DATA_W];
      end
    end
`endif
  end

  always_comb begin : next_state
    out_data_d   = out_data_q;
    read_valid_d = in_read_en;
    full_d       = full_q;
    hold_d       = hold_q;
    out_port_d   = out_port_q;
    out_wr_d     = '0;
    if (in_read_en) begin
      out_data_d = rd_data;
    end
    for (int i = 0; i < N_IN; i++) begin
      // A clearing read blocks capture this cycle; an empty port captures even when read.
      if (in_read_en && (in_addr == ADDR_W'(IoBase + 1 + i)) && full_q[i]) begin
        full_d[i] = 1'b0;
      end else if (in_port_valid[i] && !full_q[i]) begin
        full_d[i]                   = 1'b1;
        hold_d[i*DATA_W +: DATA_W]  = in_port_data[i*DATA_W +: DATA_W];
      end
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (in_write_en && (in_addr == ADDR_W'(IoBase + 1 + N_IN + j))) begin
        out_port_d[j*DATA_W +: DATA_W] = in_data;
        out_wr_d[j]                    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      read_valid_q <= 1'b0;
      full_q       <= '0;
      hold_q       <= '0;
      out_port_q   <= '0;
      out_wr_q     <= '0;
    end else begin
      out_data_q   <= out_data_d;
      read_valid_q <= read_valid_d;
      full_q       <= full_d;
      hold_q       <= hold_d;
      out_port_q   <= out_port_d;
      out_wr_q     <= out_wr_d;
    end
  end

  // RAM contents survive reset; only the write itself is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && in_write_en && is_ram) begin
      mem_q[in_addr] <= in_data;
    end
  end

  assign out_data       = out_data_q;
  assign out_read_valid = read_valid_q;
  assign in_port_ready  = ~full_q;
  assign out_port_data  = out_port_q;
  assign out_port_wr    = out_wr_q;

endmodule
